// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer for the CPU, memory and I/O domains.
//
// Synchronises the asynchronous board reset to clk, holds every domain in
// reset for HOLD_CYCLES after the synchronised release, then releases the
// NUM_CH domain resets one at a time, GAP_CYCLES apart, bit 0 first. A
// single-cycle soft_rst_req replays the sequence without re-running the
// synchroniser.
//
// Optional feature macro: RST_SEQ_SOFT_CNT_EN
//   defined   : soft_rst_cnt counts accepted warm resets (saturating at 255)
//   undefined : soft_rst_cnt is tied to 0 and no counter flops are built
//
// Ports:
//   clk           in   system clock
//   rst_n         in   board reset, asynchronous, active-low
//   soft_rst_req  in   warm-reset request, synchronous to clk
//   ch_rst_n      out  per-domain active-low resets, bit 0 released first
//   busy          out  high while any channel is still in reset
//   seq_done      out  high once all channels are released
//   soft_rst_cnt  out  number of accepted warm resets
module rst_seq_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              busy,
  output logic              seq_done,
  output logic [7:0]        soft_rst_cnt
);

  localparam int unsigned IdxW = $clog2(NUM_CH + 1);
  localparam longint unsigned MaxCnt =
      (HOLD_CYCLES > GAP_CYCLES) ? 64'(HOLD_CYCLES) : 64'(GAP_CYCLES);
  localparam longint unsigned CntLimit = 64'd1 << CNT_W;
  localparam logic [NUM_CH-1:0] ChOne = 1;

  localparam logic [1:0] StHold = 2'd0;
  localparam logic [1:0] StGap  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Reject illegal configurations at elaboration time.
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || SYNC_STAGES < 2 || NUM_CH < 1 || NUM_CH > 16 ||
      CNT_W < 1 || ((CNT_W < 32) && (MaxCnt >= CntLimit))) begin : g_param_check
    $error("rst_seq_ctrl: illegal parameter combination");
  end

  // Reset-deassert synchroniser: cleared asynchronously, shifts in ones.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_sync;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Sequencer FSM
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              done_q, done_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    done_d  = done_q;
    if (!rst_sync || soft_rst_req) begin
      state_d = StHold;
      cnt_d   = '0;
      idx_d   = '0;
      ch_d    = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        StHold: begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
            ch_d  = ChOne;
            idx_d = IdxW'(1);
            cnt_d = '0;
            if (NUM_CH == 1) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StGap;
            end
          end
        end
        StGap: begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(GAP_CYCLES)) begin
            // Channels release in order, so the reset vector is a thermometer code.
            ch_d  = (ch_q << 1) | ChOne;
            idx_d = idx_q + 1'b1;
            cnt_d = '0;
            if (idx_q == IdxW'(NUM_CH - 1)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StHold;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

  assign ch_rst_n = ch_q;
  assign seq_done = done_q;
  assign busy     = ~done_q;

`ifdef RST_SEQ_SOFT_CNT_EN
  // Requests arriving in HOLD are not counted, so a held request counts once.
  logic [7:0] soft_cnt_q, soft_cnt_d;

  always_comb begin
    soft_cnt_d = soft_cnt_q;
    if (soft_rst_req && (state_q != StHold) && (soft_cnt_q != 8'hFF)) begin
      soft_cnt_d = soft_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soft_cnt_q <= 8'h00;
    end else begin
      soft_cnt_q <= soft_cnt_d;
    end
  end

  assign soft_rst_cnt = soft_cnt_q;
`else
  assign soft_rst_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: a default-parameter instance for the
// sequencing, warm-reset and async-reset cases, plus a minimal instance
// (NUM_CH=1, HOLD=1, GAP=1, SYNC=3) for the parameter sweep and saturation.
module tb_rst_seq_ctrl;

`ifdef RST_SEQ_SOFT_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, req;
  logic [3:0] ch;
  logic       busy, done;
  logic [7:0] cnt;

  logic       rst_s, req_s;
  logic [0:0] ch_s;
  logic       busy_s, done_s;
  logic [7:0] cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (req),
    .ch_rst_n     (ch),
    .busy         (busy),
    .seq_done     (done),
    .soft_rst_cnt (cnt)
  );

  rst_seq_ctrl #(
    .NUM_CH      (1),
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (1),
    .CNT_W       (8)
  ) u_dut_s (
    .clk          (clk),
    .rst_n        (rst_s),
    .soft_rst_req (req_s),
    .ch_rst_n     (ch_s),
    .busy         (busy_s),
    .seq_done     (done_s),
    .soft_rst_cnt (cnt_s)
  );

  // Expected outputs k edges after the anchor edge (the edge on which the FSM
  // sits in HOLD with counter 0). Each entry applies from its k onwards.
  typedef struct {
    int         k;
    logic [3:0] ch;
    logic       done;
    logic       busy;
  } step_t;

  step_t seq_tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Check {ch, done, busy} for edges k_from..k_to; ticks before each k except k=0.
  task automatic check_seq(input string name, input int k_from, input int k_to);
    step_t e;
    for (int k = k_from; k <= k_to; k++) begin
      if (k != 0) tick();
      e = seq_tbl[0];
      for (int i = 0; i < 5; i++) begin
        if (k >= seq_tbl[i].k) e = seq_tbl[i];
      end
      check($sformatf("%s k=%0d", name, k), {10'd0, ch, done, busy}, {10'd0, e.ch, e.done, e.busy});
    end
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  initial begin
    seq_tbl[0] = '{k: 0,  ch: 4'b0000, done: 1'b0, busy: 1'b1};
    seq_tbl[1] = '{k: 10, ch: 4'b0001, done: 1'b0, busy: 1'b1};
    seq_tbl[2] = '{k: 14, ch: 4'b0011, done: 1'b0, busy: 1'b1};
    seq_tbl[3] = '{k: 18, ch: 4'b0111, done: 1'b0, busy: 1'b1};
    seq_tbl[4] = '{k: 22, ch: 4'b1111, done: 1'b1, busy: 1'b0};

    rst_n = 1'b0;
    rst_s = 1'b0;
    req   = 1'b0;
    req_s = 1'b0;

    // Power-on
    #100;
    check("reset_state", {ch, done, busy, cnt}, {4'b0000, 1'b0, 1'b1, 8'd0});
    check("reset_state_s", {15'd0, ch_s}, 16'd0);
    @(posedge clk);
    #8 rst_n = 1'b1;                 // just before E0
    tick();                          // E0
    check("pwr E0", {10'd0, ch, done, busy}, {10'd0, 4'b0000, 1'b0, 1'b1});
    tick();                          // E1: synchroniser output rises
    check_seq("pwr", 0, 24);         // releases at E11, E15, E19, E23

    // Warm reset from DONE
    pulse_req();
    check_seq("warm", 0, 24);
    check("warm cnt", {8'd0, cnt}, {8'd0, CntEn ? 8'd1 : 8'd0});

    // Request mid-sequence while ch_rst_n=0011
    pulse_req();
    check_seq("mid_a", 0, 15);
    pulse_req();
    check_seq("mid_b", 0, 24);
    check("mid cnt", {8'd0, cnt}, {8'd0, CntEn ? 8'd3 : 8'd0});

    // Request held for 5 cycles in DONE
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("held hi %0d", i), {10'd0, ch, done, busy}, {10'd0, 4'b0000, 1'b0, 1'b1});
    end
    req = 1'b0;
    check_seq("held", 1, 24);
    check("held cnt", {8'd0, cnt}, {8'd0, CntEn ? 8'd4 : 8'd0});

    // Asynchronous reset assertion while ch_rst_n=0011
    pulse_req();
    check_seq("async_pre", 0, 15);
    #3 rst_n = 1'b0;
    #1;
    check("async imm", {ch, done, busy, cnt}, {4'b0000, 1'b0, 1'b1, 8'd0});
    tick();
    tick();
    @(posedge clk);
    #8 rst_n = 1'b1;
    tick();                          // E0
    check("async E0", {10'd0, ch, done, busy}, {10'd0, 4'b0000, 1'b0, 1'b1});
    tick();                          // E1
    check_seq("async_post", 0, 24);

    // Parameter sweep instance
    @(posedge clk);
    #8 rst_s = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      tick();
      check($sformatf("sweep E%0d", e), {13'd0, ch_s, done_s, busy_s},
            (e >= 3) ? 16'b110 : 16'b001);
    end

    // Saturation: each request lands in DONE, the following cycle re-releases
    for (int i = 0; i < 300; i++) begin
      req_s = 1'b1;
      tick();
      req_s = 1'b0;
      if (i == 0) begin
        check("sweep req0 ch", {15'd0, ch_s}, 16'd0);
        check("sweep cnt1", {8'd0, cnt_s}, {8'd0, CntEn ? 8'd1 : 8'd0});
      end
      tick();
    end
    check("sweep sat cnt", {8'd0, cnt_s}, {8'd0, CntEn ? 8'd255 : 8'd0});
    check("sweep final", {13'd0, ch_s, done_s, busy_s}, 16'b110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
